fxp_div_seq: RTL and testbench

FXP_DIV_SEQ -- requirements
Module: fxp_div_seq

---
 rtl/fxp_div_pkg.sv | 10 +
 rtl/fxp_div_seq.sv | 129 ++++++++++++
 tb/tb_fxp_div_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: FSM state encoding and iteration-counter sizing for fxp_div_seq
package fxp_div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_e;

   function automatic int cnt_width(input int w, input int frac);
      return $clog2(w + frac + 1);
   endfunction

endpackage

// File: rtl/fxp_div_seq.sv
// fxp_div_seq: sequential restoring divider computing (dividend<<FRAC)/divisor,
// one quotient bit per cycle on magnitudes, with sign fix-up and saturation at the end.
module fxp_div_seq
   import fxp_div_pkg::*;
#(
   parameter int W    = 10,
   parameter int FRAC = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         signed_mode,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         busy,
   output logic         valid,
   output logic         ov,
   output logic         dvz
);

   localparam int N  = W + FRAC;
   localparam int CW = cnt_width(W, FRAC);
   localparam logic [N-1:0] UMAX     = N'({W{1'b1}});
   localparam logic [N-1:0] SMAX     = N'({(W-1){1'b1}});
   localparam logic [N-1:0] SMIN_MAG = SMAX + N'(1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  num_q;
   logic [W-1:0]  rem_q, den_q, quotient_q, remainder_q;
   logic          sgn_q, neg_a_q, neg_q_q, busy_q, valid_q, ov_q, dvz_q;
   logic          neg_a_d, neg_b_d, bit_d, ov_d;
   logic [W-1:0]  mag_a_d, mag_b_d, rem_d, quo_d, rem_out_d;
   logic [N-1:0]  lim_d;
   logic [W:0]    trial_d;

   // num_q shifts the numerator out at the top while quotient bits enter at the bottom
   always_comb begin
      neg_a_d   = signed_mode & dividend[W-1];
      neg_b_d   = signed_mode & divisor[W-1];
      mag_a_d   = neg_a_d ? -dividend : dividend;
      mag_b_d   = neg_b_d ? -divisor : divisor;
      trial_d   = {rem_q, num_q[N-1]};
      bit_d     = trial_d >= {1'b0, den_q};
      rem_d     = bit_d ? W'(trial_d - {1'b0, den_q}) : trial_d[W-1:0];
      lim_d     = !sgn_q ? UMAX : neg_q_q ? SMIN_MAG : SMAX;
      ov_d      = den_q != '0 && num_q > lim_d;
      quo_d     = den_q == '0 ? '0
                : !ov_d ? (neg_q_q ? W'(-num_q) : num_q[W-1:0])
                : !sgn_q ? '1
                : neg_q_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      rem_out_d = neg_a_q ? -rem_q : rem_q;
   end

   // a zero divisor skips CALC; rem_q then carries |dividend| so FIN restores the dividend
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         num_q       <= '0;
         rem_q       <= '0;
         den_q       <= '0;
         sgn_q       <= 1'b0;
         neg_a_q     <= 1'b0;
         neg_q_q     <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         ov_q        <= 1'b0;
         dvz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               valid_q <= state_q == DONE;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (start && !abort) begin
                  state_q <= divisor == '0 ? FIN : CALC;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  sgn_q   <= signed_mode;
                  neg_a_q <= neg_a_d;
                  neg_q_q <= neg_a_d ^ neg_b_d;
                  num_q   <= N'(mag_a_d) << FRAC;
                  rem_q   <= divisor == '0 ? mag_a_d : '0;
                  den_q   <= mag_b_d;
               end
            end
            CALC: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q   <= rem_d;
                  num_q   <= {num_q[N-2:0], bit_d};
                  cnt_q   <= cnt_q + CW'(1);
                  state_q <= cnt_q == CW'(N - 1) ? FIN : CALC;
               end
            end
            FIN: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  quotient_q  <= quo_d;
                  remainder_q <= rem_out_d;
                  ov_q        <= ov_d;
                  dvz_q       <= den_q == '0;
                  state_q     <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = busy_q;
   assign valid     = valid_q;
   assign ov        = ov_q;
   assign dvz       = dvz_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb_fxp_div_seq: directed-vector bench for fxp_div_seq at W=10, FRAC=3
module tb_fxp_div_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       signed_mode = 1'b0;
   logic [9:0] dividend = '0;
   logic [9:0] divisor = '0;
   logic [9:0] quotient, remainder;
   logic       busy, valid, ov, dvz;
   int         vec = 0;
   int         errs = 0;

   fxp_div_seq dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .quotient(quotient), .remainder(remainder),
      .busy(busy), .valid(valid), .ov(ov), .dvz(dvz)
   );

   always #5 clk = ~clk;

   task automatic launch(input logic m, input logic [9:0] a, input logic [9:0] b);
      @(negedge clk);
      signed_mode = m;
      dividend = a;
      divisor = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      if (!valid) n = -1;
   endtask

   task automatic test_reset;
      #12;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
      vec++; if (valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b expected 0", valid); end
      vec++; if (quotient !== 10'd0 || remainder !== 10'd0) begin errs++; $display("FAIL rst_data: got q=%0d r=%0d expected 0/0", quotient, remainder); end
      vec++; if (ov !== 1'b0 || dvz !== 1'b0) begin errs++; $display("FAIL rst_flags: got ov=%b dvz=%b expected 0/0", ov, dvz); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_dvz;
      int n;
      launch(1'b0, 10'd848, 10'd0);
      wait_valid(n);
      vec++; if (n !== 2) begin errs++; $display("FAIL dvz_lat: got %0d edges expected 2", n); end
      vec++; if (dvz !== 1'b1 || ov !== 1'b0) begin errs++; $display("FAIL dvz_flags: got dvz=%b ov=%b expected 1/0", dvz, ov); end
      vec++; if (quotient !== 10'd0 || remainder !== 10'd848) begin errs++; $display("FAIL dvz_data: got q=%0d r=%0d expected 0/848", quotient, remainder); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL dvz_busy: got %b expected 0", busy); end
      @(posedge clk);
      #1;
      vec++; if (valid !== 1'b0) begin errs++; $display("FAIL dvz_pulse: got valid=%b expected 0", valid); end
      vec++; if (remainder !== 10'd848) begin errs++; $display("FAIL dvz_hold: got r=%0d expected 848", remainder); end
   endtask

   task automatic test_unsigned;
      int n;
      launch(1'b0, 10'd431, 10'd16);
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL u_busy: got %b expected 1", busy); end
      wait_valid(n);
      vec++; if (n !== 15) begin errs++; $display("FAIL u_lat: got %0d edges expected 15", n); end
      vec++; if (quotient !== 10'd215 || remainder !== 10'd8) begin errs++; $display("FAIL u_data: got q=%0d r=%0d expected 215/8", quotient, remainder); end
      vec++; if (ov !== 1'b0 || dvz !== 1'b0) begin errs++; $display("FAIL u_flags: got ov=%b dvz=%b expected 0/0", ov, dvz); end
   endtask

   task automatic test_start_ignored;
      int n;
      launch(1'b0, 10'd431, 10'd16);
      repeat (3) @(posedge clk);
      #1;
      dividend = 10'd1023;
      divisor = 10'd1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_valid(n);
      vec++; if (n !== 11) begin errs++; $display("FAIL ign_lat: got %0d edges expected 11", n); end
      vec++; if (quotient !== 10'd215 || remainder !== 10'd8 || ov !== 1'b0) begin errs++; $display("FAIL ign_data: got q=%0d r=%0d ov=%b expected 215/8/0", quotient, remainder, ov); end
   endtask

   task automatic test_overflow;
      int n;
      launch(1'b0, 10'd1023, 10'd1);
      wait_valid(n);
      vec++; if (n !== 15) begin errs++; $display("FAIL uov_lat: got %0d edges expected 15", n); end
      vec++; if (ov !== 1'b1 || quotient !== 10'd1023) begin errs++; $display("FAIL uov_data: got ov=%b q=%0d expected 1/1023", ov, quotient); end
   endtask

   task automatic test_signed;
      int n;
      launch(1'b1, 10'b1111010101, 10'd16);
      wait_valid(n);
      vec++; if (n !== 15) begin errs++; $display("FAIL s_lat: got %0d edges expected 15", n); end
      vec++; if (quotient !== 10'd1003 || remainder !== 10'd1016 || ov !== 1'b0) begin errs++; $display("FAIL s_data: got q=%0d r=%0d ov=%b expected 1003/1016/0", quotient, remainder, ov); end
   endtask

   task automatic test_signed_boundary;
      int n;
      launch(1'b1, 10'd960, 10'd1);
      wait_valid(n);
      vec++; if (n !== 15 || quotient !== 10'd512 || ov !== 1'b0) begin errs++; $display("FAIL sb_neg_min: got n=%0d q=%0d ov=%b expected 15/512/0", n, quotient, ov); end
      launch(1'b1, 10'd64, 10'd1);
      wait_valid(n);
      vec++; if (quotient !== 10'd511 || ov !== 1'b1) begin errs++; $display("FAIL sb_pos_sat: got q=%0d ov=%b expected 511/1", quotient, ov); end
      launch(1'b1, 10'd512, 10'd1);
      wait_valid(n);
      vec++; if (quotient !== 10'd512 || ov !== 1'b1) begin errs++; $display("FAIL sb_neg_sat: got q=%0d ov=%b expected 512/1", quotient, ov); end
      launch(1'b1, 10'd512, 10'd512);
      wait_valid(n);
      vec++; if (quotient !== 10'd8 || remainder !== 10'd0 || ov !== 1'b0) begin errs++; $display("FAIL sb_min_min: got q=%0d r=%0d ov=%b expected 8/0/0", quotient, remainder, ov); end
   endtask

   task automatic test_abort;
      int seen = 0;
      launch(1'b0, 10'd431, 10'd16);
      repeat (4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ab_busy: got %b expected 0", busy); end
      repeat (20) begin
         @(posedge clk);
         #1 if (valid) seen++;
      end
      vec++; if (seen !== 0) begin errs++; $display("FAIL ab_novalid: got %0d pulses expected 0", seen); end
      vec++; if (quotient !== 10'd8 || remainder !== 10'd0 || ov !== 1'b0) begin errs++; $display("FAIL ab_hold: got q=%0d r=%0d ov=%b expected 8/0/0", quotient, remainder, ov); end
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ab_prio: got busy=%b expected 0", busy); end
   endtask

   task automatic test_reset_mid_back_to_back;
      int n;
      int seen = 0;
      launch(1'b0, 10'd431, 10'd16);
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      vec++; if (busy !== 1'b0 || quotient !== 10'd0 || remainder !== 10'd0) begin errs++; $display("FAIL rm_clear: got busy=%b q=%0d r=%0d expected 0/0/0", busy, quotient, remainder); end
      @(negedge clk) rst = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1 if (valid) seen++;
      end
      vec++; if (seen !== 0) begin errs++; $display("FAIL rm_novalid: got %0d pulses expected 0", seen); end
      launch(1'b0, 10'd848, 10'd0);
      @(posedge clk);
      #1;
      dividend = 10'd42;
      divisor = 10'd8;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      vec++; if (valid !== 1'b1 || dvz !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL b2b_edge: got valid=%b dvz=%b busy=%b expected 1/1/1", valid, dvz, busy); end
      @(posedge clk);
      #1;
      wait_valid(n);
      n++;
      vec++; if (n !== 15) begin errs++; $display("FAIL b2b_lat: got %0d edges expected 15", n); end
      vec++; if (quotient !== 10'd42 || remainder !== 10'd0 || dvz !== 1'b0) begin errs++; $display("FAIL b2b_data: got q=%0d r=%0d dvz=%b expected 42/0/0", quotient, remainder, dvz); end
   endtask

   initial begin
      test_reset();
      test_dvz();
      test_unsigned();
      test_start_ignored();
      test_overflow();
      test_signed();
      test_signed_boundary();
      test_abort();
      test_reset_mid_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
